// File: rtl/fft_bitrev_reorder_if.sv
// Sample-stream bundle between the last FFT butterfly stage and the bit-reversal reorder buffer.
interface fft_bitrev_reorder_if #(
    parameter int WIDTH = 22,
    parameter int LGSZW = 4
);
    logic               i_ce;
    logic               i_sync;
    logic [LGSZW-1:0]   i_lgsize;
    logic [2*WIDTH-1:0] i_data;
    logic [2*WIDTH-1:0] o_data;
    logic               o_valid;
    logic               o_sync;
    logic [LGSZW-1:0]   o_lgsize;
    logic               o_err;

    modport master (
        output i_ce, i_sync, i_lgsize, i_data,
        input  o_data, o_valid, o_sync, o_lgsize, o_err
    );

    modport slave (
        input  i_ce, i_sync, i_lgsize, i_data,
        output o_data, o_valid, o_sync, o_lgsize, o_err
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order frames out, size chosen per frame.
// Build option: define FFTREORDER_FFTSHIFT_EN to emit each frame with DC centred.
module fft_bitrev_reorder #(
    parameter int WIDTH     = 22,
    parameter int LGMAXSIZE = 11,
    parameter int LGMINSIZE = 3,
    parameter int LGSZW     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int               DW    = 2 * WIDTH;
    localparam int               AW    = LGMAXSIZE + 1;
    localparam logic [LGSZW-1:0] MINSZ = LGSZW'(LGMINSIZE);
    localparam logic [LGSZW-1:0] MAXSZ = LGSZW'(LGMAXSIZE);

    function automatic logic [LGSZW-1:0] clamp_size(input logic [LGSZW-1:0] lg);
        logic [LGSZW-1:0] r;
        if (lg < MINSZ) begin
            r = MINSZ;
        end else if (lg > MAXSZ) begin
            r = MAXSZ;
        end else begin
            r = lg;
        end
        return r;
    endfunction

    function automatic logic [LGMAXSIZE-1:0] last_pos(input logic [LGSZW-1:0] lg);
        return ~({LGMAXSIZE{1'b1}} << lg);
    endfunction

    // Reverse the full word, then slide the result down so only the low lg bits take part.
    function automatic logic [LGMAXSIZE-1:0] bitrev_lg(input logic [LGMAXSIZE-1:0] j,
                                                       input logic [LGSZW-1:0]     lg);
        logic [LGMAXSIZE-1:0] r;
        for (int b = 0; b < LGMAXSIZE; b++) begin
            r[b] = j[LGMAXSIZE-1-b];
        end
        return r >> (MAXSZ - lg);
    endfunction

    function automatic logic [LGMAXSIZE-1:0] read_pos(input logic [LGMAXSIZE-1:0] j,
                                                      input logic [LGSZW-1:0]     lg);
`ifdef FFTREORDER_FFTSHIFT_EN
        logic [LGMAXSIZE-1:0] half;
        half = {{(LGMAXSIZE-1){1'b0}}, 1'b1} << (lg - LGSZW'(1));
        return bitrev_lg(j ^ half, lg);
`else
        return bitrev_lg(j, lg);
`endif
    endfunction

    logic [DW-1:0]        mem_r [0:(1<<AW)-1];
    logic [DW-1:0]        ram_q_r;

    logic                 armed_r;
    logic                 wbank_r;
    logic [LGMAXSIZE-1:0] wpos_r;
    logic [LGSZW-1:0]     wsize_r;

    logic                 ractive_r;
    logic                 rbank_r;
    logic [LGMAXSIZE-1:0] rcnt_r;
    logic [LGSZW-1:0]     rsize_r;

    logic                 s1_valid_r;
    logic                 s1_sync_r;
    logic [LGSZW-1:0]     s1_lgsize_r;

    logic [DW-1:0]        o_data_r;
    logic                 o_valid_r;
    logic                 o_sync_r;
    logic [LGSZW-1:0]     o_lgsize_r;
    logic                 o_err_r;

    logic                 wr_en_s;
    logic                 abort_s;
    logic                 done_s;
    logic                 trunc_s;
    logic                 issue_s;
    logic [LGSZW-1:0]     cur_size_s;
    logic [LGMAXSIZE-1:0] cur_pos_s;
    logic [AW-1:0]        waddr_s;
    logic [AW-1:0]        raddr_s;

    // Write-position decode, frame completion, error events and read address selection
    always_comb begin
        cur_size_s = wsize_r;
        cur_pos_s  = wpos_r;
        wr_en_s    = 1'b0;
        abort_s    = 1'b0;
        done_s     = 1'b0;
        trunc_s    = 1'b0;
        issue_s    = 1'b0;
        waddr_s    = '0;
        raddr_s    = '0;

        if (bus.i_sync) begin
            cur_size_s = clamp_size(bus.i_lgsize);
            cur_pos_s  = '0;
        end else begin
            cur_size_s = wsize_r;
            cur_pos_s  = wpos_r;
        end

        // Before the first sync everything is ignored; a sync away from position 0 aborts.
        if (bus.i_ce) begin
            wr_en_s = armed_r || bus.i_sync;
            abort_s = armed_r && bus.i_sync && (wpos_r != '0);
        end else begin
            wr_en_s = 1'b0;
            abort_s = 1'b0;
        end

        done_s  = wr_en_s && (cur_pos_s == last_pos(cur_size_s));
        trunc_s = done_s && ractive_r;
        issue_s = done_s || (bus.i_ce && ractive_r);
        waddr_s = {wbank_r, cur_pos_s};

        // Index 0 of a fresh frame is fetched on the very edge that completes it.
        if (done_s) begin
            raddr_s = {wbank_r, read_pos(LGMAXSIZE'(0), cur_size_s)};
        end else begin
            raddr_s = {rbank_r, read_pos(rcnt_r, rsize_r)};
        end
    end

    // Two-bank sample RAM with a registered read port; contents need no reset
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[waddr_s] <= bus.i_data;
        end
        if (issue_s) begin
            ram_q_r <= mem_r[raddr_s];
        end
    end

    // Write/read sequencing, read pipeline stage and output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            armed_r     <= 1'b0;
            wbank_r     <= 1'b0;
            wpos_r      <= '0;
            wsize_r     <= MINSZ;
            ractive_r   <= 1'b0;
            rbank_r     <= 1'b0;
            rcnt_r      <= '0;
            rsize_r     <= MINSZ;
            s1_valid_r  <= 1'b0;
            s1_sync_r   <= 1'b0;
            s1_lgsize_r <= MINSZ;
            o_data_r    <= '0;
            o_valid_r   <= 1'b0;
            o_sync_r    <= 1'b0;
            o_lgsize_r  <= MINSZ;
            o_err_r     <= 1'b0;
        end else begin
            o_err_r <= abort_s || trunc_s;
            if (bus.i_ce) begin
                if (wr_en_s) begin
                    armed_r <= 1'b1;
                    wsize_r <= cur_size_s;
                    if (done_s) begin
                        wpos_r  <= '0;
                        wbank_r <= ~wbank_r;
                    end else begin
                        wpos_r  <= cur_pos_s + LGMAXSIZE'(1);
                    end
                end

                // A newly completed frame always takes over the read side, cutting any read in flight.
                if (done_s) begin
                    ractive_r <= 1'b1;
                    rbank_r   <= wbank_r;
                    rsize_r   <= cur_size_s;
                    rcnt_r    <= LGMAXSIZE'(1);
                end else if (ractive_r) begin
                    rcnt_r <= rcnt_r + LGMAXSIZE'(1);
                    if (rcnt_r == last_pos(rsize_r)) begin
                        ractive_r <= 1'b0;
                    end
                end

                s1_valid_r <= issue_s;
                s1_sync_r  <= done_s;
                if (done_s) begin
                    s1_lgsize_r <= cur_size_s;
                end

                o_data_r  <= s1_valid_r ? ram_q_r : '0;
                o_valid_r <= s1_valid_r;
                o_sync_r  <= s1_sync_r;
                if (s1_sync_r) begin
                    o_lgsize_r <= s1_lgsize_r;
                end
            end
        end
    end

    assign bus.o_data   = o_data_r;
    assign bus.o_valid  = o_valid_r;
    assign bus.o_sync   = o_sync_r;
    assign bus.o_lgsize = o_lgsize_r;
    assign bus.o_err    = o_err_r;
endmodule
